// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants, mode encoding and helpers for the VGA pattern generator
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_BOX     = 2'd3
    } mode_e;

    localparam logic [11:0] BAR_WHITE   = 12'hFFF;
    localparam logic [11:0] BAR_YELLOW  = 12'hFF0;
    localparam logic [11:0] BAR_CYAN    = 12'h0FF;
    localparam logic [11:0] BAR_GREEN   = 12'h0F0;
    localparam logic [11:0] BAR_MAGENTA = 12'hF0F;
    localparam logic [11:0] BAR_RED     = 12'hF00;
    localparam logic [11:0] BAR_BLUE    = 12'h00F;
    localparam logic [11:0] BAR_BLACK   = 12'h000;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    typedef struct packed {
        logic [9:0] pos;
        logic       dir;
    } axis_t;

    function automatic logic [11:0] bar_color(input logic [2:0] idx);
        logic [11:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

    // One bounce step for one axis; 11-bit sums keep pos+step from wrapping near 1023.
    function automatic axis_t axis_step(input axis_t cur, input logic [10:0] max_pos,
                                        input logic [10:0] step);
        axis_t      nxt;
        logic [10:0] pos;
        pos = {1'b0, cur.pos};
        nxt = cur;
        if (cur.dir == DIR_POS) begin
            if (pos + step >= max_pos) begin
                nxt.pos = 10'(max_pos);
                nxt.dir = DIR_NEG;
            end else begin
                nxt.pos = 10'(pos + step);
            end
        end else begin
            if (pos <= step) begin
                nxt.pos = '0;
                nxt.dir = DIR_POS;
            end else begin
                nxt.pos = 10'(pos - step);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// rtl/vga_box_mover.sv - bouncing-box position/direction registers, stepped once per frame
// Ports: i_clk, i_rst_n (sync, active low), i_frame_tick (advance one step),
//        o_box_x/o_box_y (top-left corner), o_dir_x/o_dir_y (1 = moving toward 0)
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_frame_tick,
    output logic [9:0] o_box_x,
    output logic [9:0] o_box_y,
    output logic       o_dir_x,
    output logic       o_dir_y
);

    localparam logic [10:0] MAX_X  = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] MAX_Y  = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);

    axis_t ax_q;
    axis_t ay_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ax_q <= '{pos: '0, dir: DIR_POS};
            ay_q <= '{pos: '0, dir: DIR_POS};
        end else if (i_frame_tick) begin
            ax_q <= axis_step(ax_q, MAX_X, STEP_W);
            ay_q <= axis_step(ay_q, MAX_Y, STEP_W);
        end
    end

    assign o_box_x = ax_q.pos;
    assign o_box_y = ay_q.pos;
    assign o_dir_x = ax_q.dir;
    assign o_dir_y = ay_q.dir;

endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - test-pattern source (solid, bars, checker, bouncing box) for a VGA controller
// Ports: i_clk, i_rst_n (sync, active low), i_vid_on, i_pix_x, i_pix_y, i_frame_tick,
//        i_mode (latched on frame tick), i_color (RGB444), o_rgb (registered RGB444)
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_vid_on,
    input  logic [9:0]  i_pix_x,
    input  logic [9:0]  i_pix_y,
    input  logic        i_frame_tick,
    input  logic [1:0]  i_mode,
    input  logic [11:0] i_color,
    output logic [11:0] o_rgb
);

    localparam logic [9:0]  BAR_W = 10'(H_ACTIVE / 8);
    localparam logic [10:0] BOX_W = 11'(BOX_SIZE);

    mode_e       mode_q;
    logic [9:0]  box_x;
    logic [9:0]  box_y;
    logic        dir_x;
    logic        dir_y;
    logic [9:0]  bar_idx;
    logic        in_box;
    logic [11:0] pix_d;

    vga_box_mover #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BOX_SIZE (BOX_SIZE),
        .STEP     (STEP)
    ) u_box (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_frame_tick (i_frame_tick),
        .o_box_x      (box_x),
        .o_box_y      (box_y),
        .o_dir_x      (dir_x),
        .o_dir_y      (dir_y)
    );

    assign bar_idx = i_pix_x / BAR_W;

    assign in_box = ({1'b0, i_pix_x} >= {1'b0, box_x}) &&
                    ({1'b0, i_pix_x} <  ({1'b0, box_x} + BOX_W)) &&
                    ({1'b0, i_pix_y} >= {1'b0, box_y}) &&
                    ({1'b0, i_pix_y} <  ({1'b0, box_y} + BOX_W));

    // Mode and box registers are read before this edge updates them, so a pixel
    // coinciding with the frame tick still sees the previous frame's state.
    always_comb begin
        pix_d = BAR_BLACK;
        case (mode_q)
            MODE_SOLID:   pix_d = i_color;
            MODE_BARS:    pix_d = (bar_idx < 10'd8) ? bar_color(bar_idx[2:0]) : BAR_BLACK;
            MODE_CHECKER: pix_d = (i_pix_x[5] ^ i_pix_y[5]) ? BAR_WHITE : BAR_BLACK;
            MODE_BOX:     pix_d = in_box ? i_color : BAR_BLACK;
            default:      pix_d = BAR_BLACK;
        endcase
        if (!i_vid_on) begin
            pix_d = BAR_BLACK;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rgb  <= 12'h000;
            mode_q <= MODE_SOLID;
        end else begin
            o_rgb <= pix_d;
            if (i_frame_tick) begin
                mode_q <= mode_e'(i_mode);
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - self-checking bench for vga_pattern_gen
module tb_vga_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vid_on;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        frame_tick;
    logic [1:0]  mode;
    logic [11:0] color;
    logic [11:0] rgb;

    localparam logic [11:0] COL = 12'hABC;

    always #5 clk = ~clk;

    vga_pattern_gen dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_vid_on     (vid_on),
        .i_pix_x      (pix_x),
        .i_pix_y      (pix_y),
        .i_frame_tick (frame_tick),
        .i_mode       (mode),
        .i_color      (color),
        .o_rgb        (rgb)
    );

    typedef struct {
        logic [11:0] rgb;
        string       name;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        bit          vid;
        int          x;
        int          y;
        logic [11:0] rgb;
        string       name;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Independent box model: position plus "moving toward zero" flag per axis.
    int m_bx, m_by;
    bit m_nx, m_ny;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void model_axis(inout int p, inout bit neg, input int mx);
        if (!neg) begin
            if (p + 2 >= mx) begin p = mx; neg = 1'b1; end
            else p = p + 2;
        end else begin
            if (p <= 2) begin p = 0; neg = 1'b0; end
            else p = p - 2;
        end
    endfunction

    task automatic cycle(input bit rst, input bit vid, input bit tick, input int x, input int y,
                         input logic [1:0] md, input logic [11:0] exp, input string name);
        exp_t e;
        @(negedge clk);
        rst_n      = ~rst ? 1'b0 : 1'b1;
        rst_n      = rst;
        vid_on     = vid;
        frame_tick = tick;
        pix_x      = 10'(x);
        pix_y      = 10'(y);
        mode       = md;
        sb.push_back('{rgb: exp, name: name});
        @(posedge clk);
        #1;
        if (!rst) begin
            m_bx = 0; m_by = 0; m_nx = 1'b0; m_ny = 1'b0;
        end else if (tick) begin
            model_axis(m_bx, m_nx, 608);
            model_axis(m_by, m_ny, 448);
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check(e.name, {20'd0, rgb}, {20'd0, e.rgb});
        end
    endtask

    task automatic check_box(input string name);
        check(name, {dut.box_x, dut.box_y, dut.dir_x, dut.dir_y, 10'd0},
              {10'(m_bx), 10'(m_by), m_nx, m_ny, 10'd0});
    endtask

    initial begin
        logic [1:0] cur_mode;
        rst_n = 1'b0; vid_on = 1'b0; frame_tick = 1'b0;
        pix_x = '0; pix_y = '0; mode = 2'd0; color = COL;
        m_bx = 0; m_by = 0; m_nx = 1'b0; m_ny = 1'b0;

        vecs.push_back('{2'd1, 1'b1,   85,  10, 12'hFF0, "bars_x85"});
        vecs.push_back('{2'd1, 1'b1,  639,  10, 12'h000, "bars_x639"});
        vecs.push_back('{2'd1, 1'b0,   85,  10, 12'h000, "bars_vid_off"});
        vecs.push_back('{2'd1, 1'b1,    0,   0, 12'hFFF, "bars_x0"});
        vecs.push_back('{2'd1, 1'b1,   79,   0, 12'hFFF, "bars_x79"});
        vecs.push_back('{2'd1, 1'b1,   80,   0, 12'hFF0, "bars_x80"});
        vecs.push_back('{2'd1, 1'b1,  160,   0, 12'h0FF, "bars_x160"});
        vecs.push_back('{2'd1, 1'b1,  240,   0, 12'h0F0, "bars_x240"});
        vecs.push_back('{2'd1, 1'b1,  320,   0, 12'hF0F, "bars_x320"});
        vecs.push_back('{2'd1, 1'b1,  400,   0, 12'hF00, "bars_x400"});
        vecs.push_back('{2'd1, 1'b1,  480,   0, 12'h00F, "bars_x480"});
        vecs.push_back('{2'd1, 1'b1,  560,   0, 12'h000, "bars_x560"});
        vecs.push_back('{2'd1, 1'b1,  700,   0, 12'h000, "bars_idx8"});
        vecs.push_back('{2'd1, 1'b1, 1023, 479, 12'h000, "bars_idx12"});
        vecs.push_back('{2'd2, 1'b1,   32,   0, 12'hFFF, "chk_32_0"});
        vecs.push_back('{2'd2, 1'b1,   32,  32, 12'h000, "chk_32_32"});
        vecs.push_back('{2'd2, 1'b1,    0,   0, 12'h000, "chk_0_0"});
        vecs.push_back('{2'd2, 1'b1,    0,  32, 12'hFFF, "chk_0_32"});
        vecs.push_back('{2'd2, 1'b1,   63,  63, 12'h000, "chk_63_63"});
        vecs.push_back('{2'd2, 1'b1,   64,   0, 12'h000, "chk_64_0"});
        vecs.push_back('{2'd2, 1'b0,   32,   0, 12'h000, "chk_vid_off"});
        vecs.push_back('{2'd0, 1'b1,  100, 100, COL,     "solid_mid"});
        vecs.push_back('{2'd0, 1'b1,  639, 479, COL,     "solid_corner"});
        vecs.push_back('{2'd0, 1'b0,  100, 100, 12'h000, "solid_vid_off"});
        // Four mode-change ticks after the first one leave the box at (10,10).
        vecs.push_back('{2'd3, 1'b1,   10,  10, COL,     "box_top_left"});
        vecs.push_back('{2'd3, 1'b1,   41,  41, COL,     "box_bot_right"});
        vecs.push_back('{2'd3, 1'b1,   42,  10, 12'h000, "box_right_out"});
        vecs.push_back('{2'd3, 1'b1,    9,  10, 12'h000, "box_left_out"});
        vecs.push_back('{2'd3, 1'b1,   10,  42, 12'h000, "box_below_out"});
        vecs.push_back('{2'd3, 1'b1,   10,   9, 12'h000, "box_above_out"});

        // Reset held 3 cycles with tick and video active: reset must win.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 5, 5, 2'd3, 12'h000, "reset_rgb");
        check_box("reset_box");
        check("reset_box_x0", {22'd0, dut.box_x}, 32'd0);

        // Tick during reset must not have loaded mode 3.
        cycle(1'b1, 1'b1, 1'b0, 5, 5, 2'd3, COL, "reset_mode_solid");
        cycle(1'b1, 1'b0, 1'b1, 0, 0, 2'd0, 12'h000, "first_tick");
        check("first_tick_box", {12'd0, dut.box_x, dut.box_y}, {12'd0, 10'd2, 10'd2});

        cur_mode = 2'd0;
        foreach (vecs[i]) begin
            if (vecs[i].mode != cur_mode) begin
                cycle(1'b1, 1'b0, 1'b1, 0, 0, vecs[i].mode, 12'h000, "mode_tick");
                cur_mode = vecs[i].mode;
            end
            cycle(1'b1, vecs[i].vid, 1'b0, vecs[i].x, vecs[i].y, vecs[i].mode,
                  vecs[i].rgb, vecs[i].name);
        end
        check_box("box_after_table");

        // Mode change mid-frame is deferred until the next tick.
        cycle(1'b1, 1'b0, 1'b1, 0, 0, 2'd0, 12'h000, "to_solid_tick");
        cycle(1'b1, 1'b1, 1'b0, 32, 0, 2'd2, COL, "mode_hold_1");
        cycle(1'b1, 1'b1, 1'b0, 32, 0, 2'd2, COL, "mode_hold_2");
        cycle(1'b1, 1'b1, 1'b1, 32, 0, 2'd2, COL, "mode_hold_tick");
        cycle(1'b1, 1'b1, 1'b0, 32, 0, 2'd2, 12'hFFF, "mode_applied");

        // Mid-frame reset clears mode and box.
        cycle(1'b0, 1'b1, 1'b0, 32, 0, 2'd2, 12'h000, "reset_midframe");
        cycle(1'b1, 1'b1, 1'b0, 32, 0, 2'd2, COL, "reset_mode_cleared");
        check("reset_mid_box", {12'd0, dut.box_x, dut.box_y}, 32'd0);

        // Tick every cycle: both axes return to 0 together after 8512 ticks.
        for (int t = 1; t <= 8512; t++) begin
            cycle(1'b1, 1'b0, 1'b1, 0, 0, 2'd3, 12'h000, "bounce_rgb");
            check_box("bounce_model");
            if (t == 224) check("y_top_448", {22'd0, dut.box_y}, 32'd448);
            if (t == 225) check("y_rev_446", {21'd0, dut.box_y, dut.dir_y}, {21'd0, 10'd446, 1'b1});
            if (t == 304) check("x_top_608", {21'd0, dut.box_x, dut.dir_x}, {21'd0, 10'd608, 1'b1});
            if (t == 305) check("x_rev_606", {22'd0, dut.box_x}, 32'd606);
            if (t == 608) check("x_back_0", {21'd0, dut.box_x, dut.dir_x}, {21'd0, 10'd0, 1'b0});
            if (t == 8512) check("both_zero", {12'd0, dut.box_x, dut.box_y}, 32'd0);
        end

        // Tick and pixel together: pixel sees the box still at (0,0).
        cycle(1'b1, 1'b1, 1'b1, 0, 0, 2'd3, COL, "simul_pre_tick");
        cycle(1'b1, 1'b1, 1'b0, 0, 0, 2'd3, 12'h000, "simul_post_old");
        cycle(1'b1, 1'b1, 1'b0, 2, 2, 2'd3, COL, "simul_post_new");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
